// File: rtl/move_cmd_gen.sv
// move_cmd_gen: turns four bouncy pushbutton levels into frame-synchronous,
// mutually exclusive one-cycle move/rotate command pulses with auto-repeat.
module move_cmd_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned HOLD_FRAMES     = 20,
  parameter int unsigned REPEAT_FRAMES   = 8
) (
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic       btn_fwd_in,
  input  logic       btn_back_in,
  input  logic       btn_left_in,
  input  logic       btn_right_in,
  input  logic       frame_tick_in,
  output logic       moveFwd,
  output logic       moveBack,
  output logic       rotLeft,
  output logic       rotRight,
  output logic [3:0] held_out
);

  localparam int unsigned   CW          = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    HOLD_INIT   = 8'(HOLD_FRAMES);
  localparam logic [7:0]    REPEAT_INIT = 8'(REPEAT_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;
  typedef enum logic [2:0] {CMD_NONE, CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT} cmd_t;

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] held;

  cmd_t       sel;
  cmd_t       fire;
  state_t     state_q;
  state_t     state_d;
  cmd_t       cur_cmd_q;
  cmd_t       cur_cmd_d;
  logic [7:0] fcnt_q;
  logic [7:0] fcnt_d;
  logic [3:0] pulse_q;
  logic [3:0] pulse_d;

  // Bit order {fwd, back, left, right} is kept throughout the datapath.
  assign raw = {btn_fwd_in, btn_back_in, btn_left_in, btn_right_in};

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_debounce
    logic          lvl;
    logic [CW-1:0] cnt;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (sync2[i] != lvl) begin
        if (cnt == CNT_LAST) begin
          lvl <= sync2[i];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign held[i] = lvl;
  end

  // Fixed-priority pick over the debounced levels: fwd > back > left > right.
  always_comb begin
    sel = CMD_NONE;
    if (held[3])      sel = CMD_FWD;
    else if (held[2]) sel = CMD_BACK;
    else if (held[1]) sel = CMD_LEFT;
    else if (held[0]) sel = CMD_RIGHT;
  end

  // Next-state logic: press/hold/repeat sequencing, advanced only on frame ticks.
  always_comb begin
    state_d   = state_q;
    cur_cmd_d = cur_cmd_q;
    fcnt_d    = fcnt_q;
    fire      = CMD_NONE;
    case (state_q)
      S_IDLE: begin
        if (frame_tick_in && (sel != CMD_NONE)) begin
          fire      = sel;
          cur_cmd_d = sel;
          fcnt_d    = HOLD_INIT;
          state_d   = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (sel == CMD_NONE) begin
          state_d = S_IDLE;
        end else if (frame_tick_in) begin
          if (sel != cur_cmd_q) begin
            fire      = sel;
            cur_cmd_d = sel;
            fcnt_d    = HOLD_INIT;
            state_d   = S_DELAY;
          end else if (fcnt_q == 8'd1) begin
            fire    = cur_cmd_q;
            fcnt_d  = REPEAT_INIT;
            state_d = S_REPEAT;
          end else begin
            fcnt_d = fcnt_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decode the command to fire into a one-hot output pattern.
  always_comb begin
    pulse_d = '0;
    case (fire)
      CMD_FWD:   pulse_d = 4'b1000;
      CMD_BACK:  pulse_d = 4'b0100;
      CMD_LEFT:  pulse_d = 4'b0010;
      CMD_RIGHT: pulse_d = 4'b0001;
      default:   pulse_d = '0;
    endcase
  end

  // FSM and output pulse registers.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      cur_cmd_q <= CMD_NONE;
      fcnt_q    <= '0;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_cmd_q <= cur_cmd_d;
      fcnt_q    <= fcnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign moveFwd  = pulse_q[3];
  assign moveBack = pulse_q[2];
  assign rotLeft  = pulse_q[1];
  assign rotRight = pulse_q[0];
  assign held_out = held;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Scoreboard bench for move_cmd_gen: a behavioural model predicts debounced
// levels and the cycle/command of every pulse; a monitor compares DUT output.
module tb_move_cmd_gen;

  localparam int DEB  = 4;
  localparam int HOLD = 3;
  localparam int REP  = 2;
  localparam int TICK_PERIOD = 20;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic [3:0] btn  = 4'b0000;   // {fwd, back, left, right}
  logic       tick = 1'b0;
  logic       moveFwd, moveBack, rotLeft, rotRight;
  logic [3:0] held_out;

  move_cmd_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_FRAMES    (HOLD),
    .REPEAT_FRAMES  (REP)
  ) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .btn_fwd_in   (btn[3]),
    .btn_back_in  (btn[2]),
    .btn_left_in  (btn[1]),
    .btn_right_in (btn[0]),
    .frame_tick_in(tick),
    .moveFwd      (moveFwd),
    .moveBack     (moveBack),
    .rotLeft      (rotLeft),
    .rotRight     (rotRight),
    .held_out     (held_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cmd;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state
  logic [3:0] m_s1 = '0, m_s2 = '0, m_held = '0, m_cur = '0, m_sel = '0;
  int         m_streak[4];
  bit         m_active = 0;
  int         m_k = 0;
  bit         last_tick = 0;

  wire [3:0] outs = {moveFwd, moveBack, rotLeft, rotRight};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] highest(input logic [3:0] h);
    for (int b = 3; b >= 0; b--)
      if (h[b]) return 4'(1 << b);
    return 4'b0000;
  endfunction

  // Behavioural model: pulse on the first tick of a press, then at tick
  // HOLD, HOLD+REP, HOLD+2*REP, ... counted from that first pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_held = '0; m_cur = '0;
      foreach (m_streak[b]) m_streak[b] = 0;
      m_active = 0; m_k = 0; last_tick = 0;
      exp_q.delete();
    end else begin
      cyc++;
      last_tick = tick;
      m_sel = highest(m_held);
      if (m_active && m_sel == 4'b0000) begin
        m_active = 0;
      end else if (tick) begin
        if (m_sel != 4'b0000 && (!m_active || m_sel != m_cur)) begin
          exp_q.push_back('{cmd: m_sel, cyc: cyc});
          m_active = 1; m_cur = m_sel; m_k = 0;
        end else if (m_active) begin
          m_k++;
          if (m_k >= HOLD && ((m_k - HOLD) % REP) == 0)
            exp_q.push_back('{cmd: m_cur, cyc: cyc});
        end
      end
      for (int b = 0; b < 4; b++) begin
        if (m_s2[b] != m_held[b]) begin
          m_streak[b]++;
          if (m_streak[b] == DEB) begin
            m_held[b]   = m_s2[b];
            m_streak[b] = 0;
          end
        end else begin
          m_streak[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  // Monitor: compares held levels each cycle and pops one expectation per pulse.
  always @(negedge clk) begin
    if (!rst) begin
      check("held_out", held_out, m_held);
      if (outs != 4'b0000) begin
        check("pulse_onehot", $onehot(outs), 1);
        check("pulse_after_tick", last_tick, 1);
        if (exp_q.size() == 0) begin
          check("pulse_unexpected", outs, 4'b0000);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_cmd", outs, e.cmd);
          check("pulse_cycle", cyc, e.cyc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        check("pulse_missing", outs, exp_q[0].cmd);
        void'(exp_q.pop_front());
      end
    end
  end

  // Frame tick source: periodic for directed tests, random for the soak.
  bit rand_mode = 0;
  int tphase = 0;
  always @(negedge clk) begin
    if (rand_mode) begin
      tick = ($urandom_range(0, 5) == 0);
    end else begin
      tick = (tphase == TICK_PERIOD - 1);
      tphase = (tphase + 1) % TICK_PERIOD;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int seen, c0, j;
  bit got;

  initial begin
    // Reset
    #1 rst = 1'b1;
    #1;
    check("reset_outs", outs, 4'b0000);
    check("reset_held", held_out, 4'b0000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Bounce rejection on fwd
    for (int i = 0; i < 15; i++) begin
      btn[3] = ~btn[3];
      cycles(2);
    end
    btn[3] = 1'b0;
    cycles(10);
    check("bounce_held", held_out, 4'b0000);

    // Single press of left, released before the hold expires
    btn[1] = 1'b1;
    cycles(5);
    check("left_not_yet_held", held_out[1], 1'b0);
    cycles(1);
    check("left_held_after_debounce", held_out[1], 1'b1);
    cycles(34);
    btn[1] = 1'b0;
    cycles(80);

    // Auto-repeat on back
    btn[2] = 1'b1;
    cycles(270);
    btn[2] = 1'b0;
    cycles(30);

    // Priority: fwd over right, then switch to right
    btn[3] = 1'b1;
    btn[0] = 1'b1;
    cycles(100);
    btn[3] = 1'b0;
    cycles(100);
    btn[0] = 1'b0;
    cycles(30);

    // Reset mid-hold while a repeat pulse is high
    btn[2] = 1'b1;
    seen = 0;
    for (int i = 0; i < 600 && seen < 3; i++) begin
      @(posedge clk);
      #1;
      if (outs != 4'b0000) seen++;
    end
    check("repeat_pulse_reached", seen, 3);
    #1 rst = 1'b1;
    #1;
    check("async_reset_outs", outs, 4'b0000);
    check("async_reset_held", held_out, 4'b0000);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    c0 = cyc;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (outs != 4'b0000) got = 1;
    end
    check("pulse_after_reset", got, 1);
    check("reset_to_pulse_gap_ok", ((cyc - c0) >= 6), 1);
    @(negedge clk);
    btn[2] = 1'b0;
    cycles(30);

    // Randomized soak
    rand_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        j = $urandom_range(0, 3);
        btn[j] = ~btn[j];
      end
    end
    btn = 4'b0000;
    rand_mode = 0;
    cycles(50);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_cmd_gen.md
# move_cmd_gen

Input conditioner that sits directly upstream of the player controller. It turns four raw, bouncy pushbutton levels into clean, frame-synchronous, one-cycle command pulses on moveFwd, moveBack, rotLeft and rotRight. At most one command is issued per video frame, and held buttons auto-repeat. This keeps the controller's position and direction updates to one step per frame, with a single command at a time.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 65536: consecutive cycles a synchronized input must disagree with its debounced level before that level flips. Legal range is 2 to 2^20.
- HOLD_FRAMES, default 20: frame ticks from the first pulse of a press to the first repeat pulse. Legal range is 1 to 255.
- REPEAT_FRAMES, default 8: frame ticks between repeat pulses. Legal range is 1 to 255.

Ports:
- pixel_clk_in, input, 1: the single clock.
- rst_in, input, 1: reset, asynchronous and active-high.
- btn_fwd_in, btn_back_in, btn_left_in, btn_right_in, input, 1 each: raw, asynchronous button levels, active-high.
- frame_tick_in, input, 1: one-cycle pulse, once per frame, synchronous to pixel_clk_in.
- moveFwd, moveBack, rotLeft, rotRight, output, 1 each: registered one-cycle command pulses. The four outputs are mutually exclusive.
- held_out, output, 4: debounced levels, ordered {fwd, back, left, right}.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer.
- **Debounce, per button:**
  - The counter increments while the synchronized level differs from the debounced level.
  - The counter clears whenever the two are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synchronized value and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- **Selection:** combinational, over the debounced levels, with fixed priority fwd > back > left > right. sel takes one of NONE, FWD, BACK, LEFT, RIGHT.
- **FSM:** states IDLE, DELAY, REPEAT. Registers cur_cmd (same encoding as sel) and an 8-bit frame counter fcnt. Actions only occur in a cycle with frame_tick_in=1, except where noted.
  - **IDLE**, at a tick:
    - sel≠NONE: pulse sel, cur_cmd←sel, fcnt←HOLD_FRAMES, go to DELAY.
    - Otherwise: stay in IDLE.
  - **DELAY / REPEAT, sel==NONE:** go to IDLE on any cycle, tick or not. No pulse.
  - **DELAY / REPEAT, sel≠cur_cmd (not NONE), at a tick:** treated as a new press. Pulse sel, cur_cmd←sel, fcnt←HOLD_FRAMES, go to DELAY.
  - **DELAY / REPEAT, sel==cur_cmd, at a tick:**
    - fcnt==1: pulse cur_cmd, fcnt←REPEAT_FRAMES, go to REPEAT.
    - Otherwise: fcnt←fcnt-1.
- **Pulse output:** a pulse is registered and asserts the single output line matching the command for exactly one cycle.
- **Input timing:** presses and releases between ticks are evaluated only at the next tick. A press fully released before a tick produces no pulse.

## Timing
- **Reset values:** moveFwd, moveBack, rotLeft, rotRight, held_out are all 0. State is IDLE, cur_cmd is NONE, fcnt is 0, all debounce counters are 0, synchronizer flops are 0.
- **Raw edge to held_out change:** DEBOUNCE_CYCLES+2 cycles, provided the raw level stays stable.
- **Tick to pulse:** a tick in cycle T gives the pulse in cycle T+1, high for one cycle only.
- **Pulse spacing for a continuous hold of a single button:**
  - First pulse follows the first qualifying tick.
  - The next pulse comes HOLD_FRAMES ticks later.
  - Subsequent pulses every REPEAT_FRAMES ticks.
- **Back-to-back ticks** (frame_tick_in held high) are counted as one tick per cycle. The FSM does not filter them.
- **Simultaneous buttons:** only the highest-priority button issues a pulse. When it is released, the next-priority held button is treated as a new press at the next tick.
- **Reset mid-operation:** asynchronous assertion forces all registers to their reset values immediately. A pulse being driven is truncated. After rst_in deasserts, a held button needs a full debounce before its first pulse.
- **Throughput:** at most one pulse per frame tick. No other pulse ever appears without a tick in the preceding cycle.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_FRAMES=3, REPEAT_FRAMES=2. frame_tick_in pulses every 20 cycles.

- **Bounce rejection:** btn_fwd_in toggles every 2 cycles for 30 cycles, then returns low → held_out stays 4'b0000 and no pulses appear.
- **Single press:** btn_left_in high from cycle 5. Expect:
  - held_out[1]=1 at cycle 11.
  - One rotLeft pulse in the cycle after the next tick.
  - Releasing before HOLD_FRAMES ticks gives no further pulses; state returns to IDLE.
- **Auto-repeat:** btn_back_in held for 12 ticks after debounce → moveBack pulses after ticks 1, 4, 6, 8, 10 and 12, each exactly one cycle wide.
- **Priority and switch:** btn_right_in and btn_fwd_in are held together → only moveFwd pulses. Releasing btn_fwd_in gives a rotRight pulse at the next tick, followed by repeat after 3 ticks.
- **Reset mid-hold:** assert rst_in asynchronously (off a clock edge) while in REPEAT with a pulse high → all outputs are 0 within the same cycle. After deassertion with the button still held, the first pulse follows the first tick at least 6 cycles later.
- **Mutual exclusion:** randomized buttons and ticks for 10,000 cycles, checked by assertion:
  - The output pulses are one-hot or zero.
  - Every pulse is preceded by frame_tick_in.
